// File: rtl/wave_seq_ctrl_if.sv
// Sample-stream write handshake plus the single-port sample RAM bus.
// The sequencer is the master: it owns the RAM address and write controls.
interface wave_seq_ctrl_if #(
    parameter int AW = 11,
    parameter int DW = 9
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport master (
        input  wr_valid, wr_data, ram_dout,
        output wr_ready, ram_addr, ram_we, ram_din
    );

    modport slave (
        output wr_valid, wr_data, ram_dout,
        input  wr_ready, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/wave_seq_ctrl.sv
// Arbitrary wave generator sequencer: LOAD streams samples into the sample RAM,
// PLAY reads them back at a clock-divided rate with wrap-around and loop count.
module wave_seq_ctrl #(
    parameter int AW = 11,
    parameter int DW = 9,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    wave_seq_ctrl_if.master bus,
    input  logic          load_start,
    input  logic          load_end,
    input  logic          play_start,
    input  logic          play_stop,
    input  logic [PW-1:0] period,
    input  logic [7:0]    loops,
    output logic [DW-1:0] sample_out,
    output logic          sample_strobe,
    output logic [AW:0]   length,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t        state;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] div_cnt;
    logic [PW-1:0] per_lat;
    logic [7:0]    loops_lat;
    logic [7:0]    loop_cnt;

    logic          full;
    logic          accept;
    logic          last_addr;
    logic          play_go;
    logic [PW-1:0] period_clamped;
    logic [7:0]    loop_next;
    logic [AW:0]   length_next;

    // length uses one extra bit, so its MSB alone flags a completely full RAM.
    assign full        = length[AW];
    assign bus.wr_ready = (state == LOAD) && !full;
    assign accept      = bus.wr_ready && bus.wr_valid;
    assign bus.ram_we  = accept;
    assign bus.ram_din = accept ? bus.wr_data : '0;
    assign bus.ram_addr = (state == LOAD) ? length[AW-1:0] :
                          (state == PLAY) ? rd_addr : '0;
    assign busy        = (state != IDLE);

    assign length_next    = length + (AW+1)'(accept);
    assign period_clamped = (period < PW'(2)) ? PW'(2) : period;
    assign last_addr      = ({1'b0, rd_addr} == (length - (AW+1)'(1)));
    assign loop_next      = (loop_cnt == 8'hFF) ? loop_cnt : loop_cnt + 8'd1;

    // play_stop outranks play_start only in LOAD; in IDLE a stop has nothing to abort.
    assign play_go = play_start && !load_start && (length_next != '0) &&
                     ((state == IDLE) || ((state == LOAD) && !play_stop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            length        <= '0;
            rd_addr       <= '0;
            div_cnt       <= '0;
            per_lat       <= PW'(2);
            loops_lat     <= '0;
            loop_cnt      <= '0;
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            done          <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state  <= LOAD;
                        length <= '0;
                    end
                end
                LOAD: begin
                    length <= length_next;
                    if (play_stop) begin
                        state <= IDLE;
                    end else if (load_start) begin
                        length <= '0;
                    end else if (load_end && !play_start) begin
                        state <= IDLE;
                    end
                end
                PLAY: begin
                    if (play_stop) begin
                        state <= IDLE;
                    end else if (div_cnt == '0) begin
                        sample_out    <= bus.ram_dout;
                        sample_strobe <= 1'b1;
                        div_cnt       <= per_lat - PW'(1);
                        if (last_addr) begin
                            rd_addr  <= '0;
                            loop_cnt <= loop_next;
                            if ((loops_lat != 8'd0) && (loop_next == loops_lat)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            rd_addr <= rd_addr + AW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt - PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Entry into PLAY; the RAM read of address 0 starts on the next cycle.
            if (play_go) begin
                state     <= PLAY;
                per_lat   <= period_clamped;
                div_cnt   <= period_clamped - PW'(1);
                loops_lat <= loops;
                loop_cnt  <= '0;
                rd_addr   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Directed bench for wave_seq_ctrl: behavioural sync-read RAM, expected samples
// queued at play start and popped on each sample_strobe.
module tb_wave_seq_ctrl;
    localparam int AW = 3;
    localparam int DW = 9;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_start = 1'b0;
    logic          load_end = 1'b0;
    logic          play_start = 1'b0;
    logic          play_stop = 1'b0;
    logic [PW-1:0] period = '0;
    logic [7:0]    loops = '0;
    logic [DW-1:0] sample_out;
    logic          sample_strobe;
    logic [AW:0]   length;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int we_count = 0;
    int expq[$];

    always #5 clk = ~clk;

    wave_seq_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    wave_seq_ctrl #(.AW(AW), .DW(DW), .PW(PW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .load_start(load_start),
        .load_end(load_end),
        .play_start(play_start),
        .play_stop(play_stop),
        .period(period),
        .loops(loops),
        .sample_out(sample_out),
        .sample_strobe(sample_strobe),
        .length(length),
        .busy(busy),
        .done(done)
    );

    logic [DW-1:0] mem [2**AW];

    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) begin
            mem[bus.ram_addr] <= bus.ram_din;
            we_count <= we_count + 1;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // One accepted write at the current negedge, then one idle cycle.
    task automatic applyStimulus(input int idx, input int data);
        bus.wr_valid = 1'b1;
        bus.wr_data  = DW'(data);
        #1;
        checkOutput("wr_ready", bus.wr_ready, 1);
        checkOutput("wr_we", bus.ram_we, 1);
        checkOutput("wr_addr", bus.ram_addr, idx);
        checkOutput("wr_din", bus.ram_din, data);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        checkOutput("gap_we", bus.ram_we, 0);
        tick();
    endtask

    task automatic start_play(input int per, input int lps);
        period     = PW'(per);
        loops      = 8'(lps);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        checkOutput("play_busy", busy, 1);
    endtask

    task automatic wait_strobe(input int exp_gap, input logic exp_done);
        int n = 0;
        int e;
        tick();
        n++;
        while (!sample_strobe && n < 60) begin
            tick();
            n++;
        end
        checkOutput("strobe_seen", sample_strobe, 1);
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        checkOutput("sample", sample_out, e);
        checkOutput("gap", n, exp_gap);
        checkOutput("done", done, exp_done);
    endtask

    task automatic quiet(input string name, input int cycles);
        int s = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (sample_strobe || done) s++;
        end
        checkOutput(name, s, 0);
    endtask

    initial begin
        int base;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_length", length, 0);
        checkOutput("rst_sample", sample_out, 0);
        checkOutput("rst_strobe", sample_strobe, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", bus.wr_ready, 0);
        checkOutput("rst_we", bus.ram_we, 0);
        checkOutput("rst_addr", bus.ram_addr, 0);
        checkOutput("rst_din", bus.ram_din, 0);
        rst_n = 1'b1;
        tick();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        tick();
        checkOutput("empty_play_ignored", busy, 0);

        // Load four samples with gaps between them.
        base = we_count;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkOutput("load_busy", busy, 1);
        checkOutput("load_len0", length, 0);
        for (int i = 0; i < 4; i++) applyStimulus(i, 10 * (i + 1));
        checkOutput("load_we_count", we_count - base, 4);
        checkOutput("load_length", length, 4);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        checkOutput("load_end_busy", busy, 0);
        checkOutput("load_end_length", length, 4);

        // Finite playback, two passes.
        expq.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) expq.push_back(10 * (i + 1));
        start_play(3, 2);
        for (int k = 0; k < 8; k++) wait_strobe(3, k == 7);
        checkOutput("fin_busy", busy, 0);
        tick();
        checkOutput("fin_hold", sample_out, 40);
        quiet("fin_quiet", 12);

        // period=0 clamps to 2, loops=0 runs until stopped.
        expq.delete();
        for (int i = 0; i < 18; i++) expq.push_back(10 * ((i % 4) + 1));
        start_play(0, 0);
        for (int k = 0; k < 18; k++) wait_strobe(2, 1'b0);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_done", done, 0);
        quiet("stop_quiet", 10);
        checkOutput("stop_hold", sample_out, 20);

        expq.delete();
        for (int i = 0; i < 4; i++) expq.push_back(10 * (i + 1));
        start_play(1, 1);
        for (int k = 0; k < 4; k++) wait_strobe(2, k == 3);

        // Fill the RAM with wr_valid held high, then play straight from LOAD.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        base = we_count;
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(100 + i);
            #1;
            checkOutput("full_ready", bus.wr_ready, (i < 8) ? 1 : 0);
            checkOutput("full_we", bus.ram_we, (i < 8) ? 1 : 0);
            tick();
        end
        bus.wr_valid = 1'b0;
        checkOutput("full_length", length, 8);
        checkOutput("full_we_count", we_count - base, 8);
        expq.delete();
        for (int i = 0; i < 8; i++) expq.push_back(100 + i);
        start_play(2, 1);
        #1;
        checkOutput("load_play_addr", bus.ram_addr, 0);
        for (int k = 0; k < 8; k++) wait_strobe(2, k == 7);

        // Priority: stop+start in IDLE plays; load_start in PLAY is ignored.
        tick();
        period     = PW'(4);
        loops      = 8'd0;
        play_stop  = 1'b1;
        play_start = 1'b1;
        tick();
        play_stop  = 1'b0;
        play_start = 1'b0;
        checkOutput("idle_prio_busy", busy, 1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        checkOutput("play_ls_busy", busy, 1);
        checkOutput("play_ls_length", length, 8);
        checkOutput("play_ls_ready", bus.wr_ready, 0);

        // Asynchronous reset in the middle of PLAY.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_length", length, 0);
        checkOutput("arst_sample", sample_out, 0);
        checkOutput("arst_addr", bus.ram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        checkOutput("arst_play_ignored", busy, 0);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        applyStimulus(0, 5);
        applyStimulus(1, 6);
        play_stop  = 1'b1;
        load_start = 1'b1;
        tick();
        play_stop  = 1'b0;
        load_start = 1'b0;
        checkOutput("load_prio_busy", busy, 0);
        checkOutput("load_prio_length", length, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wave_seq_ctrl.md
Name: wave_seq_ctrl

Overview:
Sequencer for the arbitrary wave generator's single-port sample RAM (sync read, 1-cycle latency). It owns the RAM address, write-enable and data-in, and has two phases: LOAD, which writes a sample stream from the host/UART side with a valid/ready handshake, and PLAY, which reads samples back at a programmable clock-divided rate, with wrap-around and a loop count. It sits between the command decoder and the RAM/DAC output register.

Parameters:
AW, 11, RAM address width; capacity 2^AW samples
DW, 9, sample width
PW, 16, sample-period counter width

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: enter LOAD, clear length
load_end  in  1  pulse: leave LOAD, keep length
wr_valid  in  1  sample valid
wr_data  in  DW  sample to store
wr_ready  out  1  controller accepts sample
play_start  in  1  pulse: begin playback
play_stop  in  1  pulse: abort LOAD or PLAY
period  in  PW  clocks per sample, latched at play_start
loops  in  8  repetitions, latched at play_start; 0 = infinite
ram_addr  out  AW  RAM address
ram_we  out  1  RAM write enable
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data, valid 1 cycle after address
sample_out  out  DW  current output sample (registered)
sample_strobe  out  1  1-cycle pulse when sample_out updates
length  out  AW+1  stored sample count, 0..2^AW
busy  out  1  high in LOAD or PLAY
done  out  1  1-cycle pulse when the finite loop count completes

Behaviour:
- Reset (async on rst_n low): state IDLE; length=0, rd_addr=0, sample_out=0, sample_strobe=0, done=0, wr_ready=0, ram_we=0, ram_addr=0, ram_din=0. Reset mid-LOAD/PLAY discards everything.
- States IDLE, LOAD, PLAY; busy = (state != IDLE).
- IDLE: load_start -> LOAD with length<=0. play_start with length!=0 -> PLAY; with length==0, ignored. play_stop ignored.
- LOAD: wr_ready = (length < 2^AW), combinational. Accept = wr_valid & wr_ready. On accept: ram_we=1, ram_addr=length[AW-1:0], ram_din=wr_data (all combinational, same cycle); length<=length+1 at the edge. Full (length==2^AW): wr_ready=0, state holds, no writes. load_end or play_stop -> IDLE, length kept. load_start -> restart, length<=0. play_start -> PLAY directly (the sample accepted that cycle is still written). Priority: play_stop > load_start > play_start > load_end.
- Outside LOAD, ram_we=0 and ram_din=0.
- PLAY entry (edge accepting play_start): P = max(period,2) latched; L = loops latched; rd_addr<=0; div_cnt<=P-1; loop_cnt<=0.
- PLAY: ram_addr = rd_addr. div_cnt decrements each cycle. Tick = (div_cnt==0): sample_out<=ram_dout (data for rd_addr, held >=2 cycles), sample_strobe<=1, div_cnt<=P-1. The first sample_out update occurs at the edge P clocks after the accepting edge; after that, one update every P clocks.
- Tick address advance: if rd_addr==length-1, set rd_addr<=0 and loop_cnt<=loop_cnt+1. Otherwise rd_addr<=rd_addr+1. loop_cnt saturates at 255.
- Finite end: if L!=0 and the wrap tick brings loop_cnt to L, the same edge sets state<=IDLE and done<=1 (1 cycle). sample_out holds the last sample.
- play_stop in PLAY -> IDLE next edge; no done. sample_out holds. A tick on that same edge is suppressed.
- In PLAY, load_start, load_end, wr_valid and play_start are ignored, and wr_ready=0.
- Arithmetic is unsigned. length is AW+1 bits so that the full value 2^AW is representable.

Test Plan:
- Reset: hold rst_n low mid-PLAY -> all outputs 0 immediately, state IDLE. Release -> play_start ignored because length=0.
- Load: load_start, write 4 samples 10,20,30,40 with wr_valid gaps -> exactly 4 ram_we pulses at addr 0..3, length=4. After load_end, busy=0.
- Play, finite: period=3, loops=2 -> sample_out 10,20,30,40,10,20,30,40 with strobes every 3 clocks; first strobe 3 clocks after play_start. done pulses with the last strobe, then busy=0 and sample_out stays 40.
- Period clamp and infinite loops: period=0 and period=1 each give a strobe every 2 clocks. loops=0 wraps indefinitely (>3 wraps checked). play_stop -> busy=0 next cycle, no done, no further strobes.
- Full: AW=3, write 10 samples with wr_valid held high -> 8 accepted, wr_ready=0 from length=8, length=8. play_start during LOAD -> PLAY begins at addr 0.
- Priority: play_stop with play_start in IDLE -> enters PLAY. In LOAD, play_stop with load_start -> IDLE with length kept. load_start in PLAY is ignored.
